// File: rtl/lfsr_count_decoder_pkg.sv
// Shared LFSR helpers: Galois step function and the readout FSM state type.
package lfsr_count_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } dec_state_t;

    // Right-shift Galois step; callers zero-extend to 64 bits and truncate the result.
    function automatic logic [63:0] lfsr_next(input logic [63:0] state, input logic [63:0] poly);
        return (state >> 1) ^ (state[0] ? poly : 64'd0);
    endfunction

endpackage

// File: rtl/lfsr_count_decoder_if.sv
// Event/readout bus between a producer/consumer (master) and the LFSR meter (slave).
interface lfsr_count_decoder_if #(
    parameter int WIDTH = 16
);
    logic             i_enable;
    logic             i_clear;
    logic             i_snap;
    logic             i_ready;
    logic             o_busy;
    logic             o_valid;
    logic             o_overflow;
    logic [WIDTH-1:0] o_count;

    modport master (
        output i_enable, i_clear, i_snap, i_ready,
        input  o_busy, o_valid, o_overflow, o_count
    );

    modport slave (
        input  i_enable, i_clear, i_snap, i_ready,
        output o_busy, o_valid, o_overflow, o_count
    );
endinterface

// File: rtl/lfsr_count_decoder.sv
// Event meter: a Galois LFSR counts events; on request a shadow LFSR walks from
// SEED one step per cycle until it matches the snapshot, yielding a binary count.
module lfsr_count_decoder
    import lfsr_count_decoder_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] POLY      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 1,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}} - 1'b1
) (
    input  logic                clock,
    input  logic                i_reset,
    lfsr_count_decoder_if.slave bus
);

    dec_state_t       state;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] snap;
    logic [WIDTH-1:0] walk;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] count_q;
    logic             overflow_q;

    logic [WIDTH-1:0] ev_next;
    logic [WIDTH-1:0] walk_next;

    assign ev_next   = WIDTH'(lfsr_next(64'(ev), 64'(POLY)));
    assign walk_next = WIDTH'(lfsr_next(64'(walk), 64'(POLY)));

    // Event LFSR runs freely of the FSM; readout FSM captures and decodes a snapshot.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state      <= IDLE;
            ev         <= SEED;
            snap       <= '0;
            walk       <= '0;
            cnt        <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.i_clear)
                ev <= SEED;
            else if (bus.i_enable)
                ev <= ev_next;

            case (state)
                IDLE: begin
                    if (bus.i_snap) begin
                        // Registered ev: this cycle's enable lands in the next snapshot.
                        snap  <= ev;
                        walk  <= SEED;
                        cnt   <= '0;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (walk == snap) begin
                        count_q    <= cnt;
                        overflow_q <= 1'b0;
                        state      <= DONE;
                    end else if (cnt == MAX_COUNT) begin
                        count_q    <= MAX_COUNT;
                        overflow_q <= 1'b1;
                        state      <= DONE;
                    end else begin
                        walk <= walk_next;
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.i_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy     = (state != IDLE);
    assign bus.o_valid    = (state == DONE);
    assign bus.o_count    = count_q;
    assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_lfsr_count_decoder.sv
// Directed bench for lfsr_count_decoder: latency, holding, overflow, reset abort, clear.
module tb_lfsr_count_decoder;

    logic clock = 1'b0;
    logic i_reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    lfsr_count_decoder_if #(.WIDTH(16)) bus  ();
    lfsr_count_decoder_if #(.WIDTH(16)) bus2 ();

    lfsr_count_decoder #(.WIDTH(16)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    lfsr_count_decoder #(.WIDTH(16), .MAX_COUNT(16'd100)) dut_small (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus2)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // Inputs and sampling both happen 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic enables(input int n);
        bus.i_enable = 1'b1;
        repeat (n) tick();
        bus.i_enable = 1'b0;
    endtask

    // Returns ticks after the snap edge until o_valid; -1 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!bus.o_valid && cycles < 70000) begin
            tick();
            cycles++;
        end
        if (!bus.o_valid) cycles = -1;
    endtask

    // Snap, check latency n+1 ticks after the snap edge, result, then handshake.
    task automatic do_snap(input string tag, input int exp_n);
        int cyc;
        bus.i_snap = 1'b1;
        tick();
        bus.i_snap = 1'b0;
        wait_valid(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_n + 1));
        chk({tag, "_count"}, 64'(bus.o_count), 64'(exp_n));
        chk({tag, "_ovf"}, 64'(bus.o_overflow), 64'd0);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(bus.o_valid), 64'd0);
        chk({tag, "_busy_drop"}, 64'(bus.o_busy), 64'd0);
    endtask

    initial begin
        int cyc;
        i_reset = 1'b0;
        bus.i_enable  = 1'b0; bus.i_clear  = 1'b0; bus.i_snap  = 1'b0; bus.i_ready  = 1'b0;
        bus2.i_enable = 1'b0; bus2.i_clear = 1'b0; bus2.i_snap = 1'b0; bus2.i_ready = 1'b0;
        #2;

        // 1: reset state, snap with no events
        do_reset();
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_count", 64'(bus.o_count), 64'd0);
        chk("rst_ovf", 64'(bus.o_overflow), 64'd0);
        do_snap("t1", 0);

        // 2: large count and accumulation across snaps
        enables(1000);
        do_snap("t2a", 1000);
        enables(5);
        do_snap("t2b", 1005);

        // 3: counting during SEARCH, ignored snaps, held result
        do_reset();
        enables(10);
        bus.i_snap = 1'b1;
        tick();
        bus.i_snap = 1'b0;
        chk("t3_busy", 64'(bus.o_busy), 64'd1);
        bus.i_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.i_snap = (i == 2);
            tick();
        end
        bus.i_enable = 1'b0;
        bus.i_snap   = 1'b0;
        wait_valid(cyc);
        chk("t3_seen", 64'(cyc >= 0), 64'd1);
        chk("t3_count", 64'(bus.o_count), 64'd10);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", 64'(bus.o_valid), 64'd1);
            chk("t3_hold_count", 64'(bus.o_count), 64'd10);
        end
        bus.i_ready = 1'b1;
        bus.i_snap  = 1'b1;   // lands in the handshake cycle: must be ignored
        tick();
        bus.i_ready = 1'b0;
        bus.i_snap  = 1'b0;
        chk("t3_snap_ignored", 64'(bus.o_busy), 64'd0);
        tick();
        chk("t3_still_idle", 64'(bus.o_busy), 64'd0);
        do_snap("t3b", 15);

        // 4: overflow on the MAX_COUNT=100 instance
        bus2.i_enable = 1'b1;
        repeat (150) tick();
        bus2.i_enable = 1'b0;
        bus2.i_snap = 1'b1;
        tick();
        bus2.i_snap = 1'b0;
        cyc = 0;
        while (!bus2.o_valid && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("t4_latency", 64'(cyc), 64'd101);
        chk("t4_count", 64'(bus2.o_count), 64'd100);
        chk("t4_ovf", 64'(bus2.o_overflow), 64'd1);
        bus2.i_ready = 1'b1;
        tick();
        bus2.i_ready = 1'b0;
        chk("t4_valid_drop", 64'(bus2.o_valid), 64'd0);

        // 5: reset aborts SEARCH and restarts the event LFSR
        enables(500);
        bus.i_snap = 1'b1;
        tick();
        bus.i_snap = 1'b0;
        repeat (10) tick();
        chk("t5_searching", 64'(bus.o_busy), 64'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("t5_busy", 64'(bus.o_busy), 64'd0);
        chk("t5_valid", 64'(bus.o_valid), 64'd0);
        do_snap("t5b", 0);

        // 6: clear wins over a simultaneous enable
        enables(20);
        bus.i_clear  = 1'b1;
        bus.i_enable = 1'b1;
        tick();
        bus.i_clear  = 1'b0;
        bus.i_enable = 1'b0;
        enables(3);
        do_snap("t6", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
